hilo_unit: RTL and testbench



---
 rtl/hilo_pkg.sv | 24 ++
 rtl/div_core.sv | 60 ++++++
 rtl/hilo_unit.sv | 99 +++++++++
 tb/tb_hilo_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO register unit and its iterative divider.
package hilo_pkg;

   localparam int WIDTH      = 32;
   localparam int HILO_W     = 2 * WIDTH;
   localparam int DIV_CYCLES = 32;
   localparam int CNT_W      = $clog2(DIV_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Two's-complement magnitude; only applied when the operand is signed and negative.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first, DIV_CYCLES iterations.
module div_core
   import hilo_pkg::*;
(
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem,
   output logic             done
);

   logic             running;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] prem;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic             fits;
   logic             last;

   // Partial remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
   always_comb begin
      rem_sh = {prem, quo_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, dvs};
      fits   = ~diff[WIDTH];
      last   = running && (cnt == CNT_W'(DIV_CYCLES - 1));
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         running <= 1'b0;
         cnt     <= '0;
         prem    <= '0;
         quo_q   <= '0;
         dvs     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= '0;
         prem    <= '0;
         quo_q   <= dividend;
         dvs     <= divisor;
      end else if (running) begin
         prem  <= fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
         quo_q <= {quo_q[WIDTH-2:0], fits};
         cnt   <= cnt + 1'b1;
         if (last)
            running <= 1'b0;
      end
   end

   assign quo  = quo_q;
   assign rem  = prem;
   assign done = last;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO architectural register pair with a multi-cycle signed/unsigned divide.
module hilo_unit
   import hilo_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              HiLoEn,
   input  logic [HILO_W-1:0] HiLoWrite,
   input  logic              DivStart,
   input  logic              DivSigned,
   input  logic [WIDTH-1:0]  Dividend,
   input  logic [WIDTH-1:0]  Divisor,
   output logic [HILO_W-1:0] HiLoRead,
   output logic              Busy,
   output logic              DivDone,
   output logic              DivByZero
);

   state_t            state, state_nxt;
   logic [HILO_W-1:0] hilo_q;
   logic              neg_quo_q;
   logic              neg_rem_q;
   logic              dbz_q;

   logic              idle;
   logic              accept;
   logic              div_zero;
   logic              core_start;
   logic              core_done;
   logic [WIDTH-1:0]  core_quo;
   logic [WIDTH-1:0]  core_rem;
   logic [WIDTH-1:0]  quo_fix;
   logic [WIDTH-1:0]  rem_fix;

   assign idle       = (state == IDLE);
   assign accept     = idle && DivStart;
   assign div_zero   = (Divisor == '0);
   assign core_start = accept && !div_zero;

   div_core u_div_core (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .start    (core_start),
      .dividend (mag(Dividend, DivSigned)),
      .divisor  (mag(Divisor, DivSigned)),
      .quo      (core_quo),
      .rem      (core_rem),
      .done     (core_done)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (DivStart) state_nxt = div_zero ? DONE : DIV;
         DIV:  if (core_done) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Quotient negates on sign mismatch; remainder follows the dividend's sign.
   assign quo_fix = cond_neg(core_quo, neg_quo_q);
   assign rem_fix = cond_neg(core_rem, neg_rem_q);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state     <= IDLE;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            neg_quo_q <= DivSigned & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
            neg_rem_q <= DivSigned & Dividend[WIDTH-1];
            dbz_q     <= div_zero;
         end else if (state == DONE) begin
            dbz_q <= 1'b0;
         end
      end
   end

   // ALU writes land only while idle; a divide result overwrites them later.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         hilo_q <= '0;
      else if (state == DONE) begin
         if (!dbz_q)
            hilo_q <= {rem_fix, quo_fix};
      end else if (idle && HiLoEn)
         hilo_q <= HiLoWrite;
   end

   assign HiLoRead  = hilo_q;
   assign Busy      = !idle;
   assign DivDone   = (state == DONE);
   assign DivByZero = dbz_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: ALU writes, signed/unsigned divides, divide-by-zero, busy drops, reset abort.
module tb_hilo_unit;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        HiLoEn;
   logic [63:0] HiLoWrite;
   logic        DivStart;
   logic        DivSigned;
   logic [31:0] Dividend;
   logic [31:0] Divisor;
   logic [63:0] HiLoRead;
   logic        Busy;
   logic        DivDone;
   logic        DivByZero;

   int n_pass  = 0;
   int n_total = 0;
   int nb, dd_at, dz_at;

   hilo_unit dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .HiLoEn    (HiLoEn),
      .HiLoWrite (HiLoWrite),
      .DivStart  (DivStart),
      .DivSigned (DivSigned),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
      .HiLoRead  (HiLoRead),
      .Busy      (Busy),
      .DivDone   (DivDone),
      .DivByZero (DivByZero)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Called on a falling edge. Returns busy-cycle count and the cycle index of DivDone/DivByZero
   // (cycle k lies between edges E(k-1) and Ek). Optional junk injection at cycle inj, reset at rst_at.
   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int inj, input int rst_at,
                          output int nbusy, output int done_at, output int zero_at);
      nbusy = 0; done_at = 0; zero_at = 0;
      DivSigned = sgn; Dividend = a; Divisor = b; DivStart = 1'b1;
      @(posedge Clk);
      #1 DivStart = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge Clk);
         if (k == rst_at) begin
            Rst_n = 1'b0;
            break;
         end
         if (Busy) nbusy++;
         if (DivDone && done_at == 0) done_at = k;
         if (DivByZero && zero_at == 0) zero_at = k;
         if (!Busy) break;
         if (k == inj) begin
            HiLoEn = 1'b1; HiLoWrite = 64'h1234_5678_9ABC_DEF0;
            DivStart = 1'b1; DivSigned = 1'b0; Dividend = 32'd1000; Divisor = 32'd1;
         end else if (k == inj + 1) begin
            HiLoEn = 1'b0; DivStart = 1'b0;
         end
      end
      HiLoEn = 1'b0; DivStart = 1'b0;
   endtask

   initial begin
      Rst_n = 1'b0; HiLoEn = 1'b0; HiLoWrite = '0; DivStart = 1'b0;
      DivSigned = 1'b0; Dividend = '0; Divisor = '0;
      repeat (2) @(negedge Clk);
      chk("rst_hilo", HiLoRead, 64'd0);
      chk("rst_busy", {63'd0, Busy}, 64'd0);
      chk("rst_done", {63'd0, DivDone}, 64'd0);
      chk("rst_dbz", {63'd0, DivByZero}, 64'd0);
      Rst_n = 1'b1;
      @(negedge Clk);

      // ALU write, visible one cycle later
      HiLoEn = 1'b1; HiLoWrite = 64'h0000_0001_0000_0002;
      @(negedge Clk);
      HiLoEn = 1'b0;
      chk("alu_write", HiLoRead, 64'h0000_0001_0000_0002);
      chk("alu_busy", {63'd0, Busy}, 64'd0);

      // DIVU 100/7 = 14 r 2
      run_div(1'b0, 32'd100, 32'd7, 0, 0, nb, dd_at, dz_at);
      chk("divu_busy_cycles", 64'(nb), 64'd33);
      chk("divu_done_cycle", 64'(dd_at), 64'd33);
      chk("divu_dbz", 64'(dz_at), 64'd0);
      chk("divu_result", HiLoRead, {32'd2, 32'd14});

      // back-to-back DIV -7/2 = -3 r -1
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, nb, dd_at, dz_at);
      chk("div_neg_busy", 64'(nb), 64'd33);
      chk("div_neg_result", HiLoRead, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

      // most-negative / -1 truncates
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, nb, dd_at, dz_at);
      chk("div_ovf_result", HiLoRead, {32'd0, 32'h8000_0000});

      // divide by zero leaves HI/LO alone
      HiLoEn = 1'b1; HiLoWrite = 64'hAAAA_AAAA_5555_5555;
      @(negedge Clk);
      HiLoEn = 1'b0;
      chk("preload", HiLoRead, 64'hAAAA_AAAA_5555_5555);
      run_div(1'b0, 32'd5, 32'd0, 0, 0, nb, dd_at, dz_at);
      chk("dbz_busy_cycles", 64'(nb), 64'd1);
      chk("dbz_done_cycle", 64'(dd_at), 64'd1);
      chk("dbz_flag_cycle", 64'(dz_at), 64'd1);
      chk("dbz_hilo", HiLoRead, 64'hAAAA_AAAA_5555_5555);
      chk("dbz_flag_clear", {63'd0, DivByZero}, 64'd0);

      // requests during a divide are dropped
      run_div(1'b0, 32'd100, 32'd7, 10, 0, nb, dd_at, dz_at);
      chk("drop_busy_cycles", 64'(nb), 64'd33);
      chk("drop_result", HiLoRead, {32'd2, 32'd14});
      @(negedge Clk);
      chk("drop_no_restart", {63'd0, Busy}, 64'd0);
      chk("drop_hilo_hold", HiLoRead, {32'd2, 32'd14});

      // reset during iteration 15 aborts and clears
      run_div(1'b0, 32'd100, 32'd7, 0, 16, nb, dd_at, dz_at);
      #1;
      chk("abort_busy", {63'd0, Busy}, 64'd0);
      chk("abort_hilo", HiLoRead, 64'd0);
      chk("abort_done", {63'd0, DivDone}, 64'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      run_div(1'b0, 32'd9, 32'd3, 0, 0, nb, dd_at, dz_at);
      chk("post_rst_busy", 64'(nb), 64'd33);
      chk("post_rst_result", HiLoRead, {32'd0, 32'd3});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
